// File: rtl/ain_cond_pkg.sv
// Shared types and default constants for the ain_conditioner slice.
// Holds the debounce FSM state encoding and the default parameter values.
package ain_cond_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/ain_conditioner_sync_ff.sv
// sync_ff: single-bit multi-flop synchroniser, async active-low reset to 0.
// Ports: clk, reset (active-low), d (async input), q (synchronised output).
module sync_ff
  import ain_cond_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh <= '0;
    end else begin
      sh <= {sh[STAGES-2:0], d};
    end
  end

  assign q = sh[STAGES-1];

endmodule

// File: rtl/ain_conditioner.sv
// ain_conditioner: synchronise and debounce a 2-bit switch symbol for the
// sequence detector. Ports: clk, reset (async, active-low), raw_ain[1:0],
// ain[1:0] (debounced), ain_valid (1-cycle pulse per accepted change),
// busy (settling), change_count[7:0] when AIN_COND_CHANGE_CNT_EN is defined.
module ain_conditioner
  import ain_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw_ain,
  output logic [1:0] ain,
  output logic       ain_valid,
  output logic       busy
`ifdef AIN_COND_CHANGE_CNT_EN
  ,
  output logic [7:0] change_count
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] sync_ain;

  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync_ff #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (raw_ain[i]),
      .q    (sync_ain[i])
    );
  end

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cand;
  logic [1:0]       cand_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       ain_nxt;
  logic             valid_nxt;

  // Both bits form one symbol: any difference from the candidate restarts
  // the count, so a partially-settled symbol can never be committed.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    ain_nxt   = ain;
    valid_nxt = 1'b0;
    unique case (state)
      STABLE: begin
        if (sync_ain != ain) begin
          cand_nxt  = sync_ain;
          cnt_nxt   = '0;
          state_nxt = SETTLING;
        end
      end
      SETTLING: begin
        if (sync_ain == ain) begin
          state_nxt = STABLE;
        end else if (sync_ain != cand) begin
          cand_nxt = sync_ain;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          ain_nxt   = cand;
          valid_nxt = 1'b1;
          state_nxt = STABLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= STABLE;
      cand      <= '0;
      cnt       <= '0;
      ain       <= '0;
      ain_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      ain       <= ain_nxt;
      ain_valid <= valid_nxt;
      busy      <= (state_nxt == SETTLING);
    end
  end

`ifdef AIN_COND_CHANGE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      change_count <= '0;
    end else if (ain_valid) begin
      change_count <= change_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ain_conditioner.sv
// Randomised and directed bench for ain_conditioner.
// Reference: commit when the last D+1 synchronised samples agree and differ.
module tb_ain_conditioner;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk;
  logic       reset;
  logic [1:0] raw_ain;
  logic [1:0] ain;
  logic       ain_valid;
  logic       busy;
`ifdef AIN_COND_CHANGE_CNT_EN
  logic [7:0] change_count;
`endif

  int checks;
  int passes;

  ain_conditioner dut (
    .clk      (clk),
    .reset    (reset),
    .raw_ain  (raw_ain),
    .ain      (ain),
    .ain_valid(ain_valid),
    .busy     (busy)
`ifdef AIN_COND_CHANGE_CNT_EN
    ,
    .change_count(change_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sync value seen at an edge is the raw value sampled
  // S edges earlier (zero right after reset). A change is accepted when
  // D+1 consecutive seen values agree and differ from the current ain.
  logic [1:0] rawq[$];
  logic [1:0] syncq[$];
  logic [1:0] m_ain;
  logic       m_valid;
  logic       m_busy;
  int         m_cnt;

  always @(posedge clk or negedge reset) begin
    logic [1:0] s;
    bit         run;
    if (!reset) begin
      rawq.delete();
      syncq.delete();
      m_ain   = 2'b00;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_cnt   = 0;
    end else begin
      s = (rawq.size() >= S) ? rawq[rawq.size()-S] : 2'b00;
      rawq.push_back(raw_ain);
      syncq.push_back(s);
      if (rawq.size() > 32) void'(rawq.pop_front());
      if (syncq.size() > 32) void'(syncq.pop_front());
      run = (syncq.size() >= D + 1);
      for (int i = 1; i <= D + 1; i++)
        if (run && syncq[syncq.size()-i] != s) run = 1'b0;
      m_valid = 1'b0;
      if (run && s != m_ain) begin
        m_ain   = s;
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 256;
      end
      m_busy = (s != m_ain);
    end
  end

  task automatic go_idle();
    raw_ain = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int pulses;
    int vk;
    reset   = 1'b0;
    raw_ain = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({ain, ain_valid, busy} !== 4'b0000)
        $display("FAIL reset_hold: got ain=%b v=%b busy=%b want 00/0/0",
                 ain, ain_valid, busy);
      else passes++;
    end
    reset  = 1'b1;
    pulses = 0;
    vk     = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL reset_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (ain_valid) begin
        pulses++;
        vk = k;
      end
    end
    checks++;
    if (pulses != 1 || vk - 1 != S + D)
      $display("FAIL reset_release: got pulses=%0d lat=%0d want 1/%0d",
               pulses, vk - 1, S + D);
    else passes++;
    checks++;
    if (ain !== 2'b11)
      $display("FAIL reset_final_ain: got %b want 11", ain);
    else passes++;
  endtask

  task automatic test_clean_change();
    int pulses;
    int vk;
    int bk;
    go_idle();
    raw_ain = 2'b10;
    pulses  = 0;
    vk      = -1;
    bk      = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL clean_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (busy && bk < 0) bk = k;
      if (ain_valid) begin
        pulses++;
        vk = k;
      end
    end
    checks++;
    if (bk - 1 != S)
      $display("FAIL clean_busy_rise: got %0d want %0d", bk - 1, S);
    else passes++;
    checks++;
    if (pulses != 1 || vk - 1 != S + D)
      $display("FAIL clean_commit: got pulses=%0d lat=%0d want 1/%0d",
               pulses, vk - 1, S + D);
    else passes++;
    checks++;
    if ({ain, ain_valid, busy} !== 4'b1000)
      $display("FAIL clean_final: got %b/%b/%b want 10/0/0",
               ain, ain_valid, busy);
    else passes++;
  endtask

  task automatic test_glitch();
    int pulses;
    bit saw_busy;
    go_idle();
    raw_ain  = 2'b01;
    pulses   = 0;
    saw_busy = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) raw_ain = 2'b00;
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL glitch_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (ain_valid) pulses++;
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (pulses != 0 || !saw_busy)
      $display("FAIL glitch_reject: got pulses=%0d busy_seen=%0b want 0/1",
               pulses, saw_busy);
    else passes++;
    checks++;
    if ({ain, busy} !== 3'b000)
      $display("FAIL glitch_final: got ain=%b busy=%b want 00/0", ain, busy);
    else passes++;
  endtask

  task automatic test_bounce();
    int pulses;
    int vk;
    bit saw10;
    go_idle();
    raw_ain = 2'b11;
    pulses  = 0;
    vk      = -1;
    saw10   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) raw_ain = 2'b10;
      if (k == 3) raw_ain = 2'b11;
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL bounce_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (ain == 2'b10) saw10 = 1'b1;
      if (ain_valid) begin
        pulses++;
        vk = k;
      end
    end
    checks++;
    if (pulses != 1 || vk - 4 != S + D || saw10)
      $display("FAIL bounce: got pulses=%0d lat=%0d saw10=%0b want 1/%0d/0",
               pulses, vk - 4, saw10, S + D);
    else passes++;
    checks++;
    if (ain !== 2'b11)
      $display("FAIL bounce_final: got %b want 11", ain);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int pulses;
    int vk;
    go_idle();
    raw_ain = 2'b01;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ain, ain_valid, busy} !== 4'b0000)
      $display("FAIL midrst_hold: got %b/%b/%b want 00/0/0",
               ain, ain_valid, busy);
    else passes++;
    reset  = 1'b1;
    pulses = 0;
    vk     = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL midrst_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (ain_valid) begin
        pulses++;
        vk = k;
      end
    end
    checks++;
    if (pulses != 1 || vk - 1 != S + D || ain !== 2'b01)
      $display("FAIL midrst_commit: got pulses=%0d lat=%0d ain=%b want 1/%0d/01",
               pulses, vk - 1, ain, S + D);
    else passes++;
  endtask

  task automatic test_random();
    int hold;
    int last_v;
    go_idle();
    hold   = 0;
    last_v = -100;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        raw_ain = 2'($urandom_range(0, 3));
        hold    = $urandom_range(1, 9);
      end
      hold--;
      @(negedge clk);
      checks++;
      if ({ain, ain_valid, busy} !== {m_ain, m_valid, m_busy})
        $display("FAIL random_model k=%0d: got %b/%b/%b want %b/%b/%b",
                 k, ain, ain_valid, busy, m_ain, m_valid, m_busy);
      else passes++;
      if (ain_valid) begin
        checks++;
        if (k - last_v < D + 1)
          $display("FAIL random_spacing k=%0d: got %0d want >=%0d",
                   k, k - last_v, D + 1);
        else passes++;
        last_v = k;
      end
    end
  endtask

`ifdef AIN_COND_CHANGE_CNT_EN
  task automatic test_change_count();
    logic [1:0] seq[12];
    seq = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11,
            2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
    go_idle();
    checks++;
    if (change_count !== 8'd0)
      $display("FAIL cnt_reset: got %0d want 0", change_count);
    else passes++;
    for (int i = 0; i < 12; i++) begin
      raw_ain = seq[i];
      repeat (8) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (change_count !== 8'd12 || int'(change_count) != m_cnt)
      $display("FAIL cnt_seq: got %0d want 12 (model %0d)",
               change_count, m_cnt);
    else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (change_count !== 8'd0)
      $display("FAIL cnt_rst_again: got %0d want 0", change_count);
    else passes++;
    reset = 1'b1;
  endtask
`endif

  initial begin
    checks  = 0;
    passes  = 0;
    reset   = 1'b0;
    raw_ain = 2'b00;
    test_reset();
    test_clean_change();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_random();
`ifdef AIN_COND_CHANGE_CNT_EN
    test_change_count();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
